// File: rtl/seven_seg_scanner.sv
// Five-digit common-anode seven-segment scanner fed by the BCD converter.
// Digits are shadowed on load so a scan never shows a half-converted value.

module seven_seg_digit (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h3F;
    if (blank) seg = 7'h7F;
    else begin
      case (bcd)
        4'd0: seg = 7'h40;
        4'd1: seg = 7'h79;
        4'd2: seg = 7'h24;
        4'd3: seg = 7'h30;
        4'd4: seg = 7'h19;
        4'd5: seg = 7'h12;
        4'd6: seg = 7'h02;
        4'd7: seg = 7'h78;
        4'd8: seg = 7'h00;
        4'd9: seg = 7'h10;
        default: seg = 7'h3F;
      endcase
    end
  end
endmodule

module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_AN      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [3:0]        bcd0,
  input  logic [3:0]        bcd1,
  input  logic [3:0]        bcd2,
  input  logic [3:0]        bcd3,
  input  logic [3:0]        bcd4,
  input  logic              blank_lead,
  output logic [6:0]        seg,
  output logic [NUM_AN-1:0] an,
  output logic              frame_tick
);
  localparam int NUM_DIG = 5;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [NUM_DIG-1:0][3:0] shadow;
  logic [CW-1:0]           cnt;
  logic [2:0]              idx;
  logic [NUM_DIG-1:0][6:0] dig_seg;
  logic [NUM_DIG:0]        nz_above;
  logic [6:0]              seg_nxt;
  logic [NUM_AN-1:0]       an_nxt;
  logic                    slot_end;

  // nz_above[i]: some shadow digit at position i or higher is nonzero
  assign nz_above[NUM_DIG] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < NUM_DIG; i++) begin : g_dig
      logic blank;
      assign nz_above[i] = (shadow[i] != 4'd0) | nz_above[i+1];
      if (i == 0) begin : g_ones
        assign blank = 1'b0;
      end else begin : g_upper
        assign blank = blank_lead & ~nz_above[i];
      end
      seven_seg_digit u_dig (
        .bcd   (shadow[i]),
        .blank (blank),
        .seg   (dig_seg[i])
      );
    end
  endgenerate

  assign slot_end = (cnt == CNT_LAST);

  always_comb begin
    seg_nxt = 7'h7F;
    an_nxt  = '1;
    for (int j = 0; j < NUM_DIG; j++) begin
      if (idx == 3'(j)) begin
        seg_nxt   = dig_seg[j];
        an_nxt[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      cnt        <= '0;
      idx        <= '0;
      seg        <= 7'h7F;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (load) shadow <= {bcd4, bcd3, bcd2, bcd1, bcd0};
      frame_tick <= slot_end && (idx == 3'd4);
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4: scan order,
// frame_tick, capture, encoding, leading-zero blanking and reset/load priority.

module tb_seven_seg_scanner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0, bcd4 = '0;
  logic       blank_lead = 1'b0;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int e = 0;  // edges since reset release

  seven_seg_scanner #(.REFRESH_DIV(4), .NUM_AN(8)) dut (
    .clk(clk), .reset(reset), .load(load),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4),
    .blank_lead(blank_lead), .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic set_bcd(input logic [3:0] d4, d3, d2, d1, d0);
    bcd4 = d4; bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
  endtask

  // Pins show slot k during edges e with ((e-1)/4)%5 == k; sample mid-slot.
  task automatic check_frame(input string tag, input logic [4:0][6:0] exp_seg);
    logic [7:0] exp_an;
    for (int k = 0; k < 5; k++) begin
      int guard = 0;
      while (!((((e - 1) % 4) == 1) && ((((e - 1) / 4) % 5) == k)) && guard < 40) begin
        tick();
        guard++;
      end
      if (guard >= 40) chk({tag, "_timeout"}, 1, 0);
      case (k)
        0: exp_an = 8'hFE;
        1: exp_an = 8'hFD;
        2: exp_an = 8'hFB;
        3: exp_an = 8'hF7;
        default: exp_an = 8'hEF;
      endcase
      chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'(exp_an));
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(exp_seg[k]));
    end
  endtask

  initial begin
    int pulses;
    // reset state
    repeat (3) tick();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_ft", 32'(frame_tick), 32'h0);

    // first update after release shows digit 0
    reset = 1'b0;
    e = 0;
    tick();
    chk("rel_an", 32'(an), 32'hFE);
    chk("rel_seg", 32'(seg), 32'h40);
    pulses = 0;
    while (e < 40) begin
      tick();
      if (frame_tick) pulses++;
      if (e == 4)  chk("idx_hold_an", 32'(an), 32'hFE);
      if (e == 5)  chk("idx_adv_an", 32'(an), 32'hFD);
      if (e == 20) chk("ft_at20", 32'(frame_tick), 32'h1);
      if (e == 21) chk("ft_at21", 32'(frame_tick), 32'h0);
    end
    chk("ft_pulses", 32'(pulses), 32'd2);

    // 01243, no blanking; then blanking with the same shadow
    set_bcd(4'd0, 4'd1, 4'd2, 4'd4, 4'd3);
    pulse_load();
    check_frame("v1243", {7'h40, 7'h79, 7'h24, 7'h19, 7'h30});
    blank_lead = 1'b1;
    tick();
    check_frame("v1243b", {7'h7F, 7'h79, 7'h24, 7'h19, 7'h30});

    // zero with blanking: single "0"
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    pulse_load();
    check_frame("zero_b", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    // non-decimal code: dash, counts as nonzero for blanking
    set_bcd(4'd0, 4'd0, 4'hC, 4'd0, 4'd0);
    pulse_load();
    check_frame("dash_b", {7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40});

    // remaining encodings
    blank_lead = 1'b0;
    set_bcd(4'd9, 4'd8, 4'd7, 4'd6, 4'd5);
    pulse_load();
    check_frame("v98765", {7'h10, 7'h00, 7'h78, 7'h02, 7'h12});

    // reset wins over a simultaneous load
    set_bcd(4'd5, 4'd5, 4'd5, 4'd5, 4'd5);
    reset = 1'b1;
    load  = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    e = 0;
    tick();
    chk("rl_an", 32'(an), 32'hFE);
    chk("rl_seg", 32'(seg), 32'h40);
    check_frame("rl_zero", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    // inputs ignored without load
    set_bcd(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    tick();
    check_frame("noload", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Display stage directly downstream of the binary-to-BCD converter. Captures the five BCD digits on the converter's done pulse into shadow registers, so the display never shows a half-converted value. Time-multiplexes the digits onto a common-anode seven-segment display with optional leading-zero blanking. Drives board segment and anode pins; upper anodes unused.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20
NUM_AN, 8, physical anode count; anodes NUM_AN-1..5 held off permanently

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
load  input  1  capture strobe; wired to converter done
bcd0  input  4  ones digit
bcd1  input  4  tens digit
bcd2  input  4  hundreds digit
bcd3  input  4  thousands digit
bcd4  input  4  ten-thousands digit
blank_lead  input  1  1 = suppress leading zeros
seg  output  7  {g,f,e,d,c,b,a}, active-low, registered
an  output  NUM_AN  digit enables, active-low, registered
frame_tick  output  1  one-cycle pulse when scan index wraps 4->0

Behaviour:
- Reset is synchronous, active-high; clock clk. While reset is high, on each edge: shadow digits = 0, slot counter = 0, index = 0, seg = 7'h7F, an = all ones, frame_tick = 0. Reset overrides a simultaneous load.
- Capture: on an edge with load=1, all five shadow digits take bcd0..bcd4 together. With load=0, shadow values hold. Inputs are ignored between loads.
- Slot counter: counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and the index advances 0->1->2->3->4->0.
- frame_tick: asserted for exactly the one cycle after the edge where the index goes 4->0.
- Output register: every edge, seg and an load from the current index and shadow digits. Latency: index change at edge N -> pins at edge N+1. Load at edge N -> shadow at N+1 -> pins no earlier than N+2, and only when that digit is in its slot.
- Anode: an[index] = 0; all other bits = 1. Bits 5..NUM_AN-1 are always 1.
- Blanking: digit i (i=1..4) is blank when blank_lead=1 and shadow digits i..4 are all 0. Blank means seg = 7'h7F with the anode still enabled. Digit 0 is never blanked, so value 0 shows a single "0".
- Encoding (active-low hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Codes 10..15: seg = 7'h3F (dash, g only). Such a digit counts as nonzero for blanking.
- blank_lead changes take effect on the next output register update; no capture is needed.
- load during an active slot: the new value appears mid-slot, one cycle after the shadow update. Tearing is acceptable only at this single boundary.
- Reset mid-scan: everything restarts from index 0 with digits 0. After reset release, the first output update shows digit 0: an = ...11110, seg = 40.

Test Plan:
- REFRESH_DIV=4. Reset 3 cycles, release, no load -> edge 1 after release: an=8'hFE, seg=7'h40. Index advances every 4 cycles. frame_tick pulses once per 20 cycles.
- Load 1243 (bcd4..0 = 0,1,2,4,3), blank_lead=0 -> slots 0..4 show seg 30, 19, 24, 79, 40 on an FE, FD, FB, F7, EF.
- Same value, blank_lead=1 -> slot 4 shows seg=7F with an=EF; slots 0..3 unchanged.
- Load value 0 with blank_lead=1 -> slot 0 shows 40; slots 1..4 show 7F.
- Set bcd2=4'hC, pulse load -> slot 2 shows 3F. With blank_lead=1 and bcd4=bcd3=0, slots 3 and 4 blank and slot 2 still shows the dash.
- Pulse load and reset on the same edge with inputs 5,5,5,5,5 -> shadow stays 0. After release, slot 0 shows 40. Change bcd inputs with load=0 -> display unchanged.
